sopc_pio_in_edge: RTL and testbench
===================================

# sopc_pio_in_edge

Parametrised Avalon-MM input PIO with edge capture and maskable interrupt, the successor to the single-bit input-only PIO in the SOPC system. It samples a WIDTH-bit input bus and latches selected edges into a sticky capture register that software clears with write-1-to-clear. It raises a level interrupt to the Nios II when any unmasked captured bit is set. It sits on the system interconnect as an s1 slave, one instance per external status group (e.g. LAN interrupt lines).

## Interface
- WIDTH, 1, input bus width, legal 1..32
- EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- address  in  2  register select
- chipselect  in  1  slave select, qualifies writes
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- in_port  in  WIDTH  external inputs, asynchronous to clk
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0 data (RO): current data_in.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask (RW).
  - 3 edgecapture (R, write-1-to-clear).
- Bits above WIDTH in readdata always 0.
- data_in is in_port, or the synchronizer output when the synchronizer is compiled in (see Configuration).
- Edge detect: d1 <= data_in each clk.
  - Rising: data_in & ~d1.
  - Falling: ~data_in & d1.
  - Any: data_in ^ d1.
- Capture: edgecapture[i] sets on edge[i] and holds until cleared.
- Clear: chipselect & ~write_n & address==3 & writedata[i] clears edgecapture[i].
- Simultaneous edge and clear on the same bit: set wins, and the bit stays 1.
- Write to address 2: irqmask <= writedata[WIDTH-1:0] when chipselect & ~write_n.
- Writes to addresses 0 and 1 have no effect.
- irq = |(edgecapture & irqmask), combinational from registers, with no extra flop.
- readdata <= mux(address) every clk; no read strobe is needed and reads have no side effects.

## Timing
- Reset values: readdata 0, irqmask 0, edgecapture 0, d1 0, synchronizer flops 0, irq 0.
- Because d1 resets to 0, an input already high at reset release registers as a rising (or any) edge on the first cycle after release. Software clears it at init.
- Read latency: 1 clk. readdata reflects the address sampled on the previous edge.
- Edge-to-capture, no sync: an in_port change before edge N sets edgecapture on edge N, and irq asserts immediately after edge N if the bit is masked in.
- Edge-to-capture, sync compiled in: 2 additional clks.
- Minimum detectable pulse: 1 clk high and 1 clk low at data_in.
- Write effects: irqmask and edgecapture update on the clk edge sampling the write. readdata shows the new value on the following read cycle. irq follows in the same cycle as the register change.
- Asynchronous reset mid-operation clears all state immediately, independent of clk. irq deasserts.

## Configuration
- SOPC_PIO_IN_SYNC_EN:
  - Defined: two-flop synchronizer per bit between in_port and data_in, adding 2 clk latency.
  - Undefined: data_in = in_port directly. The integrator guarantees in_port is synchronous to clk.
- Register map and all other behaviour are identical in both builds.

## Test plan
- Reset with in_port=0, WIDTH=4, EDGE_TYPE=0 → readdata 0, irq 0; read addr 2 and addr 3 → 0.
- Drive in_port 4'b0101, read addr 0 → readdata 32'h5 one clk after the address (three clks later with sync).
- Rising edge on bit 2 with irqmask=4'b0100 → edgecapture 4'b0100 and irq=1; write 32'h4 to addr 3 → edgecapture 0, irq=0 the same cycle.
- EDGE_TYPE=2, toggle bit 0 high then low with a clear of bit 0 written on the cycle of the falling edge → edgecapture[0] stays 1 (set wins).
- irqmask=0 with edges on all bits → edgecapture 4'hF, irq 0; write irqmask 32'h8 → irq 1 next cycle; write 32'hFFFF_FFFF to addr 2 → readback 32'h0000_000F.
- Assert reset_n low mid-capture with irq=1 → irq and all registers 0 without a clk edge; in_port held high at release → edgecapture shows 1 for those bits.

Source files
------------

// File: rtl/sopc_pio_in_edge_if.sv
// Avalon-MM s1 slave bus for sopc_pio_in_edge: address, chipselect, write strobe and data,
// registered read data. The master modport is the interconnect side.
interface sopc_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_pio_in_edge.sv
// Avalon-MM input PIO with sticky edge capture (write-1-to-clear) and maskable level irq.
// Define SOPC_PIO_IN_SYNC_EN to insert a two-flop synchronizer on in_port (+2 clk latency).
module sopc_pio_in_edge #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sopc_pio_in_edge_if.slave    s1,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    assign wr_en = s1.chipselect & ~s1.write_n;

`ifdef SOPC_PIO_IN_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    assign data_in = sync2_q;
`else
    assign data_in = in_port;
`endif

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_bits = data_in & ~d1_q;
        end else if (EDGE_TYPE == 1) begin
            edge_bits = ~data_in & d1_q;
        end else begin
            edge_bits = data_in ^ d1_q;
        end
    end

    // A new edge overrides a simultaneous clear so no event is ever lost.
    always_comb begin
        capture_d = capture_q;
        if (wr_en && (s1.address == 2'd3)) begin
            capture_d = capture_q & ~s1.writedata[WIDTH-1:0];
        end
        capture_d = capture_d | edge_bits;
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (s1.address == 2'd2)) begin
            mask_d = s1.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        unique case (s1.address)
            2'd0:    readdata_d[WIDTH-1:0] = data_in;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q       <= '0;
            capture_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            d1_q       <= data_in;
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign s1.readdata = readdata_q;
    assign irq         = |(capture_q & mask_q);

endmodule

// File: tb/tb_sopc_pio_in_edge.sv
// Self-checking bench: a rising-edge and an any-edge instance share stimulus and are compared
// every cycle against an event-level reference model, plus directed vectors and corner cases.
module tb_sopc_pio_in_edge;

`ifdef SOPC_PIO_IN_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq_a, irq_b;

    int checks;
    int errors;

    sopc_pio_in_edge_if bus_a ();
    sopc_pio_in_edge_if bus_b ();

    sopc_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .s1      (bus_a),
        .in_port (in_port),
        .irq     (irq_a)
    );

    sopc_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .s1      (bus_b),
        .in_port (in_port),
        .irq     (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-instance capture/mask, shared input history of sampled in_port.
    logic [3:0]  m_cap [2];
    logic [3:0]  m_mask[2];
    logic [31:0] m_rd  [2];
    logic [3:0]  m_prev;
    logic [3:0]  m_hist[3];
    int          m_type[2];

    typedef struct {
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [3:0]  inp;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t vt[21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cap[i]  = '0;
            m_mask[i] = '0;
            m_rd[i]   = '0;
        end
        m_prev = '0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
    endtask

    task automatic model_step(input logic [1:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic [3:0] inp);
        logic [3:0] din;
        logic [3:0] ev;
        bit         do_wr;
`ifdef SOPC_PIO_IN_SYNC_EN
        din = m_hist[Lat-1];
`else
        din = inp;
`endif
        do_wr = cs && !wn;
        for (int i = 0; i < 2; i++) begin
            // Edge events from the sampled level now vs. one clk earlier.
            ev = '0;
            for (int b = 0; b < 4; b++) begin
                if (m_type[i] == 0 && din[b] && !m_prev[b]) ev[b] = 1'b1;
                if (m_type[i] == 2 && din[b] != m_prev[b]) ev[b] = 1'b1;
            end
            m_rd[i] = 32'(a == 2'd0 ? din : a == 2'd2 ? m_mask[i] : a == 2'd3 ? m_cap[i] : 4'd0);
            for (int b = 0; b < 4; b++) begin
                if (ev[b]) m_cap[i][b] = 1'b1;
                else if (do_wr && a == 2'd3 && wd[b]) m_cap[i][b] = 1'b0;
            end
            if (do_wr && a == 2'd2) m_mask[i] = wd[3:0];
        end
        m_prev    = din;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = inp;
    endtask

    function automatic logic model_irq(input int i);
        return (m_cap[i] & m_mask[i]) != 4'd0;
    endfunction

    task automatic drive(input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [3:0] inp);
        bus_a.address = a;  bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = wd;
        bus_b.address = a;  bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = wd;
        in_port = inp;
    endtask

    // One bus cycle: drive after negedge, compare both instances 1 time unit after posedge.
    task automatic cycle(input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [3:0] inp);
        @(negedge clk);
        drive(a, cs, wn, wd, inp);
        model_step(a, cs, wn, wd, inp);
        @(posedge clk);
        #1;
        check("model_rd_a", bus_a.readdata, m_rd[0]);
        check("model_irq_a", 32'(irq_a), 32'(model_irq(0)));
        check("model_rd_b", bus_b.readdata, m_rd[1]);
        check("model_irq_b", 32'(irq_b), 32'(model_irq(1)));
    endtask

    task automatic set_vec(input int idx, input logic [1:0] a, input logic cs, input logic wn,
                           input logic [31:0] wd, input logic [3:0] inp, input logic [31:0] rd,
                           input logic irq);
        vt[idx].a = a; vt[idx].cs = cs; vt[idx].wn = wn; vt[idx].wd = wd;
        vt[idx].inp = inp; vt[idx].rd = rd; vt[idx].irq = irq;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_type[0]  = 0;
        m_type[1]  = 2;
        model_reset();

        //        idx addr cs wn  wdata         in     rd            irq   (instance A, rising)
        set_vec(0,  2'd2, 0, 1, 32'h0,        4'h0, 32'h0,        0);
        set_vec(1,  2'd3, 0, 1, 32'h0,        4'h0, 32'h0,        0);
        set_vec(2,  2'd0, 0, 1, 32'h0,        4'h5, 32'h5,        0);
        set_vec(3,  2'd2, 1, 0, 32'h4,        4'h5, 32'h0,        1);
        set_vec(4,  2'd3, 0, 1, 32'h0,        4'h5, 32'h5,        1);
        set_vec(5,  2'd3, 1, 0, 32'h4,        4'h5, 32'h5,        0);
        set_vec(6,  2'd3, 0, 1, 32'h0,        4'h5, 32'h1,        0);
        set_vec(7,  2'd3, 1, 0, 32'h1,        4'h5, 32'h1,        0);
        set_vec(8,  2'd0, 0, 1, 32'h0,        4'h0, 32'h0,        0);
        set_vec(9,  2'd3, 0, 1, 32'h0,        4'h4, 32'h0,        1);
        set_vec(10, 2'd3, 1, 0, 32'h4,        4'h4, 32'h4,        0);
        set_vec(11, 2'd2, 1, 0, 32'h0,        4'h0, 32'h4,        0);
        set_vec(12, 2'd3, 0, 1, 32'h0,        4'hF, 32'h0,        0);
        set_vec(13, 2'd2, 1, 0, 32'h8,        4'hF, 32'h0,        1);
        set_vec(14, 2'd2, 1, 0, 32'hFFFF_FFFF, 4'hF, 32'h8,       1);
        set_vec(15, 2'd2, 0, 1, 32'h0,        4'hF, 32'h0000_000F, 1);
        set_vec(16, 2'd0, 1, 0, 32'h0,        4'hF, 32'hF,        1);
        set_vec(17, 2'd1, 1, 0, 32'hFFFF,     4'hF, 32'h0,        1);
        set_vec(18, 2'd3, 0, 1, 32'h0,        4'hF, 32'hF,        1);
        set_vec(19, 2'd3, 0, 0, 32'hF,        4'hF, 32'hF,        1);
        set_vec(20, 2'd3, 0, 1, 32'h0,        4'hF, 32'hF,        1);

        reset_n = 1'b0;
        drive(2'd0, 1'b0, 1'b1, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", bus_a.readdata, 32'h0);
        check("reset_irq", 32'(irq_a), 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;

`ifndef SOPC_PIO_IN_SYNC_EN
        for (int i = 0; i < 21; i++) begin
            cycle(vt[i].a, vt[i].cs, vt[i].wn, vt[i].wd, vt[i].inp);
            check($sformatf("vec%0d_rd", i), bus_a.readdata, vt[i].rd);
            check($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(vt[i].irq));
        end
`else
        for (int i = 0; i < 21; i++) cycle(vt[i].a, vt[i].cs, vt[i].wn, vt[i].wd, vt[i].inp);
`endif

        // Set-wins on the any-edge instance: falling edge on bit 0 coincides with its clear.
        cycle(2'd0, 1'b0, 1'b1, 32'h0,        4'h0);
        repeat (Lat) cycle(2'd0, 1'b0, 1'b1, 32'h0, 4'h0);
        cycle(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0);
        cycle(2'd3, 1'b0, 1'b1, 32'h0,        4'h0);
        check("b_cleared", bus_b.readdata, 32'h0);
        cycle(2'd3, 1'b0, 1'b1, 32'h0,        4'h1);
        repeat (Lat) cycle(2'd3, 1'b0, 1'b1, 32'h0, 4'h1);
        cycle(2'd3, 1'b1, 1'b0, 32'h1,        4'h1);
        repeat (Lat) cycle(2'd3, 1'b0, 1'b1, 32'h0, 4'h0);
        cycle(2'd3, 1'b1, 1'b0, 32'h1,        4'h0);
        cycle(2'd3, 1'b0, 1'b1, 32'h0,        4'h0);
        check("set_wins_b", bus_b.readdata, 32'h1);

        // Async reset with irq high on instance A.
        cycle(2'd2, 1'b1, 1'b0, 32'hF,        4'hF);
        repeat (Lat + 1) cycle(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        check("pre_reset_irq", 32'(irq_a), 32'h1);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_irq_a", 32'(irq_a), 32'h0);
        check("async_irq_b", 32'(irq_b), 32'h0);
        check("async_rd_a", bus_a.readdata, 32'h0);
        check("async_rd_b", bus_b.readdata, 32'h0);
        drive(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        #1 reset_n = 1'b1;
        repeat (Lat + 1) cycle(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        cycle(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
        check("release_high_cap", bus_a.readdata, 32'hF);
        cycle(2'd3, 1'b1, 1'b0, 32'hF, 4'hF);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
